sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO that succeeds the fixed 8-bit asynchronous FIFO in the FIFO verification environment. Data width, depth and almost-full/almost-empty thresholds are configurable. It adds an occupancy count, a registered read-valid strobe, and single-cycle overflow/underflow error pulses. It sits between a producer and a consumer sharing one clock domain. Its wr/rd port naming matches the existing FIFO bench interface, so the write and read agents reuse their clocking-block style.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_mem.sv | 29 ++
 rtl/sync_fifo_param.sv | 86 ++++++++
 tb/tb_sync_fifo_param.sv | 129 ++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised single-clock FIFO: pointer sizing,
// the occupancy arithmetic type and elaboration-time parameter checks.
package fifo_pkg;

  localparam int unsigned MAX_PTR_W = 16;

  // Wide enough for any supported DEPTH; narrowed to the real width at the top.
  typedef logic [MAX_PTR_W-1:0] count_t;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

`define FIFO_ELAB_CHECK(label, cond, msg) \
  if (!(cond)) begin : label \
    $error(msg); \
  end

// File: rtl/fifo_mem.sv
// Simple dual-port storage: one write port, one registered read port.
module fifo_mem #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage array is never reset; only the output register is.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO: pointers, occupancy count, threshold flags and
// one-cycle overflow/underflow/read-valid pulses around fifo_mem.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned AW = PW - 1;

  `FIFO_ELAB_CHECK(g_chk_depth, is_pow2(DEPTH) && (DEPTH >= 4), "DEPTH must be a power of two and at least 4")
  `FIFO_ELAB_CHECK(g_chk_thresh, (AE_THRESH < AF_THRESH) && (AF_THRESH <= DEPTH), "need AE_THRESH < AF_THRESH <= DEPTH")
  `FIFO_ELAB_CHECK(g_chk_width, PW <= MAX_PTR_W, "DEPTH too large for count_t")

  logic [PW-1:0] wr_ptr, rd_ptr, cnt_q;
  logic          wr_acc, rd_acc;
  count_t        cnt_nxt;

  // Flags come from the registered count, so acceptance sees start-of-cycle state.
  assign full         = (cnt_q == PW'(DEPTH));
  assign empty        = (cnt_q == '0);
  assign almost_full  = (cnt_q >= PW'(AF_THRESH));
  assign almost_empty = (cnt_q <= PW'(AE_THRESH));
  assign count        = cnt_q;

  assign wr_acc  = wr_en & ~full;
  assign rd_acc  = rd_en & ~empty;
  assign cnt_nxt = count_t'(cnt_q) + count_t'(wr_acc) - count_t'(rd_acc);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt_q     <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      cnt_q     <= cnt_nxt[PW-1:0];
      rd_valid  <= rd_acc;
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;
    end
  end

  // Wrap bits are kept for lap tracking/debug; occupancy is carried by cnt_q.
  logic wrap_unused;
  assign wrap_unused = wr_ptr[PW-1] ^ rd_ptr[PW-1] ^ (|cnt_nxt[MAX_PTR_W-1:PW]);

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc & ~rst),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_data),
    .re    (rd_acc & ~rst),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed + randomized bench for sync_fifo_param against a queue-based model.
module tb_sync_fifo_param;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AF     = 14;
  localparam int AE     = 2;

  logic              clk = 1'b0;
  logic              rst, wr_en, rd_en;
  logic [DATA_W-1:0] wr_data, rd_data;
  logic              rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0]        count;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] q[$];
  logic [7:0] exp_rd = 8'h00;
  bit         exp_valid, exp_ovf, exp_unf;
  int         nwr;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, advance model at the edge, check #1 after.
  task automatic step(input bit r, input bit we, input logic [7:0] wd, input bit re);
    bit was_full, was_empty, wa, ra;
    @(negedge clk);
    rst = r; wr_en = we; wr_data = wd; rd_en = re;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    @(posedge clk);
    if (r) begin
      q.delete();
      exp_rd = 8'h00; exp_valid = 0; exp_ovf = 0; exp_unf = 0;
    end else begin
      wa = we && !was_full;
      ra = re && !was_empty;
      if (ra) exp_rd = q.pop_front();
      if (wa) q.push_back(wd);
      exp_valid = ra; exp_ovf = we && !wa; exp_unf = re && !ra;
    end
    #1;
    chk("count",        32'(count),        32'(q.size()));
    chk("empty",        32'(empty),        32'(q.size() == 0));
    chk("full",         32'(full),         32'(q.size() == DEPTH));
    chk("almost_full",  32'(almost_full),  32'(q.size() >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(q.size() <= AE));
    chk("rd_data",      32'(rd_data),      32'(exp_rd));
    chk("rd_valid",     32'(rd_valid),     32'(exp_valid));
    chk("overflow",     32'(overflow),     32'(exp_ovf));
    chk("underflow",    32'(underflow),    32'(exp_unf));
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    // Reset with requests asserted (ignored), then idle.
    step(1, 1, 8'h77, 1);
    step(1, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);

    // Fill 0x00..0x0F, then one rejected write.
    for (int i = 0; i < DEPTH; i++) step(0, 1, 8'(i), 0);
    step(0, 1, 8'hAA, 0);
    step(0, 0, 8'h00, 0);

    // Drain all, then one rejected read (rd_data must hold 0x0F).
    for (int i = 0; i < DEPTH; i++) step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);

    // Simultaneous at count=5.
    for (int i = 0; i < 5; i++) step(0, 1, 8'($urandom), 0);
    for (int i = 0; i < 6; i++) step(0, 1, 8'($urandom), 1);

    // Simultaneous when full.
    while (q.size() < DEPTH) step(0, 1, 8'($urandom), 0);
    step(0, 1, 8'hEE, 1);

    // Simultaneous when empty.
    while (q.size() > 0) step(0, 0, 8'h00, 1);
    step(0, 1, 8'h3C, 1);
    step(0, 0, 8'h00, 1);

    // Wrap-around: 40 writes, occupancy kept within 3..10.
    nwr = 0;
    while (q.size() < 3) begin step(0, 1, 8'($urandom), 0); nwr++; end
    while (nwr < 40) begin
      int op;
      op = int'($urandom_range(0, 3));
      if (q.size() <= 3 && (op == 1 || op == 3)) op = 0;
      if (q.size() >= 10 && op == 0) op = 1;
      case (op)
        0: begin step(0, 1, 8'($urandom), 0); nwr++; end
        1: step(0, 0, 8'h00, 1);
        2: begin step(0, 1, 8'($urandom), 1); nwr++; end
        default: step(0, 0, 8'h00, 0);
      endcase
    end
    while (q.size() > 0) step(0, 0, 8'h00, 1);

    // Reset at count=9 during a simultaneous write/read.
    for (int i = 0; i < 9; i++) step(0, 1, 8'($urandom), 0);
    step(1, 1, 8'h99, 1);
    step(0, 1, 8'h5C, 0);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
